// File: rtl/four_way_gf2_mult_seq.sv
// Sequential four-way split carry-less multiplier over GF(2)[x].
// Ports: clk, rst (async high), start, a/b [N] in; busy, done, c [2N] out.
module four_way_gf2_mult_seq #(
    parameter int N = 521,
    parameter int D = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] c
);
    localparam int L  = (N + 3) / 4;
    localparam int K  = (L + D - 1) / D;
    localparam int LW = 2 * L - 1;
    localparam int TW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, ACC, COMB, DONE} state_t;

    state_t         state_q, state_d;
    logic [L-1:0]   a_q [4];
    logic [L-1:0]   a_d [4];
    logic [L-1:0]   b_q [4];
    logic [L-1:0]   b_d [4];
    logic [LW-1:0]  acc_q [16];
    logic [LW-1:0]  acc_d [16];
    logic [TW-1:0]  t_q, t_d;
    logic [2*N-1:0] c_q, c_d;
    logic [4*L-1:0] a_ext, b_ext;
    logic [LW-1:0]  coef [7];
    logic [2*N-1:0] prod;

    assign a_ext = (4*L)'(a);
    assign b_ext = (4*L)'(b);

    // Fold the 16 limb products into seven coefficients and overlap them
    // at limb offsets; bits at or above 2N are always zero and dropped.
    always_comb begin
        for (int k = 0; k < 7; k++) coef[k] = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                coef[i+j] = coef[i+j] ^ acc_q[4*i+j];
        prod = '0;
        for (int k = 0; k < 7; k++)
            for (int x = 0; x < LW; x++)
                if (L*k + x < 2*N)
                    prod[L*k+x] = prod[L*k+x] ^ coef[k][x];
    end

    always_comb begin
        int            s;
        logic [L-1:0]  abit;
        s       = 0;
        abit    = '0;
        state_d = state_q;
        t_d     = t_q;
        c_d     = c_q;
        for (int q = 0; q < 4; q++) begin
            a_d[q] = a_q[q];
            b_d[q] = b_q[q];
        end
        for (int q = 0; q < 16; q++) acc_d[q] = acc_q[q];
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    for (int q = 0; q < 4; q++) begin
                        a_d[q] = a_ext[L*q +: L];
                        b_d[q] = b_ext[L*q +: L];
                    end
                    for (int q = 0; q < 16; q++) acc_d[q] = '0;
                    t_d     = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                // Digit bits past the limb top (L not a multiple of D)
                // are skipped.
                for (int i = 0; i < 4; i++) begin
                    for (int m = 0; m < D; m++) begin
                        s = int'(t_q) * D + m;
                        if (s < L) begin
                            abit = a_q[i] >> s;
                            if (abit[0]) begin
                                for (int j = 0; j < 4; j++)
                                    acc_d[4*i+j] = acc_d[4*i+j]
                                                 ^ (LW'(b_q[j]) << s);
                            end
                        end
                    end
                end
                t_d = t_q + TW'(1);
                if (t_q == TW'(K - 1)) state_d = COMB;
            end
            COMB: begin
                c_d     = prod;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            c_q     <= '0;
            for (int q = 0; q < 4; q++) begin
                a_q[q] <= '0;
                b_q[q] <= '0;
            end
            for (int q = 0; q < 16; q++) acc_q[q] <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            c_q     <= c_d;
            for (int q = 0; q < 4; q++) begin
                a_q[q] <= a_d[q];
                b_q[q] <= b_d[q];
            end
            for (int q = 0; q < 16; q++) acc_q[q] <= acc_d[q];
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign c    = c_q;

endmodule
